// File: rtl/btn_pkg.sv
// ============================================================================
// btn_pkg -- shared types and default constants for the button conditioner
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;

  // Counter width able to hold 0..limit without wrapping.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : btn_pkg

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// btn_debounce_ch -- one button channel: synchronizer, debounce FSM, hold timer
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic level_out,
  output logic press_out,
  output logic release_out,
  output logic hold_out
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic              sync_meta_q;
  logic              sync_q;
  btn_state_t        state_q,    state_d;
  logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q,    level_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic              hold_q,     hold_d;
  logic              hold_adv;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= btn_in;
      sync_q      <= sync_meta_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_RELEASED;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;
    hold_adv   = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (sync_q) begin
          state_d  = ST_PRESS_PEND;
          db_cnt_d = '0;
        end
      end

      ST_PRESS_PEND: begin
        if (!sync_q) begin
          state_d  = ST_RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      ST_PRESSED: begin
        hold_adv = 1'b1;
        if (!sync_q) begin
          state_d  = ST_RELEASE_PEND;
          db_cnt_d = '0;
        end
      end

      ST_RELEASE_PEND: begin
        // The releasing edge itself does not advance the hold timer, so a
        // hold pulse can never land on the same cycle as the release pulse.
        if (sync_q) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
          hold_adv = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_RELEASED;
          db_cnt_d  = '0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
          hold_adv = 1'b1;
        end
      end

      default: begin
        state_d  = ST_RELEASED;
        db_cnt_d = '0;
      end
    endcase

    if (hold_adv && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_q == HOLD_PRE);
    end

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;
  assign hold_out    = hold_q;

endmodule : btn_debounce_ch

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// btn_conditioner -- NUM_BTN independent debounced buttons with press,
//                    release and long-press pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] level_out,
  output logic [NUM_BTN-1:0] press_out,
  output logic [NUM_BTN-1:0] release_out,
  output logic [NUM_BTN-1:0] hold_out
);

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .btn_in      (btn_in[gi]),
      .level_out   (level_out[gi]),
      .press_out   (press_out[gi]),
      .release_out (release_out[gi]),
      .hold_out    (hold_out[gi])
    );
  end

endmodule : btn_conditioner

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// tb_btn_conditioner -- self-checking bench for btn_conditioner
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 10;

  logic         clk_in   = 1'b0;
  logic         rst_n_in = 1'b0;
  logic [N-1:0] btn_in   = '0;
  logic [N-1:0] level_out, press_out, release_out, hold_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: accepted level flips once D+1 consecutive synchronized
  // samples disagree with it; hold age counts edges spent with level high.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release, m_hold;
  int run_len [N];
  int age     [N];

  btn_conditioner #(
    .NUM_BTN         (N),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .btn_in      (btn_in),
    .level_out   (level_out),
    .press_out   (press_out),
    .release_out (release_out),
    .hold_out    (hold_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0;
    m_press = '0; m_release = '0; m_hold = '0;
    for (int i = 0; i < N; i++) begin
      run_len[i] = 0;
      age[i]     = 0;
    end
  endtask

  task automatic model_edge();
    m_press = '0; m_release = '0; m_hold = '0;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_level[i]) run_len[i]++;
      else                       run_len[i] = 0;
      if (run_len[i] == D + 1) begin
        run_len[i] = 0;
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          m_press[i] = 1'b1;
          age[i]     = 0;
        end else begin
          m_release[i] = 1'b1;
        end
      end else if (m_level[i] && age[i] < H) begin
        age[i]++;
        if (age[i] == H) m_hold[i] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic settle();
    btn_in = '0;
    repeat (3 * D) tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      btn_in = N'($urandom);
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== '0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d got lvl=%b prs=%b rel=%b hld=%b exp all 0",
                 k, level_out, press_out, release_out, hold_out);
      end
    end
    btn_in   = '0;
    rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL post_reset_idle got %b/%b/%b/%b exp %b/%b/%b/%b",
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
    end
  endtask

  task automatic test_press();
    int first_p = -1;
    int n_p     = 0;
    int others  = 0;
    int first_r = -1;
    btn_in = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL press_model k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (press_out[0]) begin
        n_p++;
        if (first_p < 0) first_p = k;
      end
      if (press_out[3:1] != 3'b000 || level_out[3:1] != 3'b000) others++;
    end
    n_cmp++;
    if (first_p != 6 || n_p != 1) begin
      n_bad++;
      $display("FAIL press_latency got edge=%0d pulses=%0d exp edge=6 pulses=1", first_p, n_p);
    end
    n_cmp++;
    if (others != 0) begin
      n_bad++;
      $display("FAIL press_isolation got %0d active cycles on other channels exp 0", others);
    end
    btn_in = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL release_model k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (release_out[0] && first_r < 0) first_r = k;
    end
    n_cmp++;
    if (first_r != 6) begin
      n_bad++;
      $display("FAIL release_latency got edge=%0d exp edge=6", first_r);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    int n_p = 0;
    btn_in = 4'b0010;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) btn_in = '0;
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL glitch_model k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (press_out[1] || level_out[1]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL glitch_reject got %0d active cycles exp 0", bad);
    end
    btn_in = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) btn_in = '0;
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL repress_model k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (press_out[1]) n_p++;
    end
    n_cmp++;
    if (n_p != 1) begin
      n_bad++;
      $display("FAIL repress_count got %0d exp 1", n_p);
    end
    settle();
  endtask

  task automatic test_hold();
    int seen   = 0;
    int n_h    = 0;
    int h_off  = -1;
    int r_off  = -1;
    btn_in = 4'b0100;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (press_out[2]) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL hold_press_timeout got no press_out[2] exp press within 12 cycles");
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL hold_model j=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", j,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (hold_out[2]) begin
        n_h++;
        h_off = j;
      end
    end
    n_cmp++;
    if (n_h != 1 || h_off != 10) begin
      n_bad++;
      $display("FAIL hold_pulse got pulses=%0d offset=%0d exp pulses=1 offset=10", n_h, h_off);
    end
    btn_in = '0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (release_out[2] && r_off < 0) r_off = j;
    end
    n_cmp++;
    if (r_off != 6) begin
      n_bad++;
      $display("FAIL hold_release got offset=%0d exp 6", r_off);
    end
  endtask

  task automatic test_release_glitch();
    int seen  = 0;
    int bad   = 0;
    int h_off = -1;
    btn_in = 4'b1000;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (press_out[3]) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL rglitch_press_timeout got no press_out[3] exp press within 12 cycles");
    end
    for (int j = 1; j <= 14; j++) begin
      if (j == 3) btn_in = '0;
      if (j == 5) btn_in = 4'b1000;
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL rglitch_model j=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", j,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
      if (!level_out[3] || release_out[3]) bad++;
      if (hold_out[3]) h_off = j;
    end
    n_cmp++;
    if (bad != 0 || h_off != 10) begin
      n_bad++;
      $display("FAIL rglitch_hold got bad=%0d hold_offset=%0d exp bad=0 hold_offset=10", bad, h_off);
    end
    settle();
  endtask

  task automatic test_all_press();
    int bad = 0;
    btn_in = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 6) begin
        if (press_out !== 4'b1111) bad++;
      end else if (press_out !== 4'b0000) begin
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL all_press got %0d wrong cycles exp 0", bad);
    end
    settle();
  endtask

  task automatic test_async_reset();
    int bad     = 0;
    int first_p = -1;
    btn_in = 4'b1111;
    repeat (3) tick();
    #3 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({level_out, press_out, release_out, hold_out} !== '0) begin
      n_bad++;
      $display("FAIL areset_pend got %b/%b/%b/%b exp all 0", level_out, press_out, release_out, hold_out);
    end
    model_reset();
    tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if (level_out !== 4'b1111) begin
      n_bad++;
      $display("FAIL areset_pressed_pre got lvl=%b exp 1111", level_out);
    end
    #3 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({level_out, press_out, release_out, hold_out} !== '0) begin
      n_bad++;
      $display("FAIL areset_pressed got %b/%b/%b/%b exp all 0", level_out, press_out, release_out, hold_out);
    end
    model_reset();
    repeat (2) tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (release_out !== 4'b0000) bad++;
      if (press_out === 4'b1111 && first_p < 0) first_p = k;
    end
    n_cmp++;
    if (bad != 0 || first_p != 6) begin
      n_bad++;
      $display("FAIL areset_repress got press_edge=%0d release_cycles=%0d exp 6 and 0", first_p, bad);
    end
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n_in = 1'b1;
      end
      tick();
      n_cmp++;
      if ({level_out, press_out, release_out, hold_out} !== {m_level, m_press, m_release, m_hold}) begin
        n_bad++;
        $display("FAIL random c=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", c,
                 level_out, press_out, release_out, hold_out, m_level, m_press, m_release, m_hold);
      end
    end
    settle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press();
    test_glitch();
    test_hold();
    test_release_glitch();
    test_all_press();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_btn_conditioner

`default_nettype wire
